avalon_sram_agent: RTL and testbench

Avalon-MM pipelined agent (slave) that answers the word-addressed data-side requests issued by the core's Avalon data master (`avm_main_*`). It backs the bus with an internal single-port word memory and returns read data with fixed latency, readdatavalid and response. Waitrequest back-pressure comes from a pending-read limit and an external stall input. It is the responder used in simulation benches and small FPGA builds behind the core wrapper.

---
 rtl/avalon_sram_agent.sv | 163 ++++++++++++++++
 tb/tb_avalon_sram_agent.sv | 269 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/avalon_sram_agent.sv
// ---------------------------------------------------------------------------
// avalon_sram_agent
//   Avalon-MM pipelined agent backed by an internal single-port word memory.
//   Reads return after a fixed ReadLatency with readdatavalid and response.
//   Back-pressure comes from a pending-read limit and an external stall input.
//
// Parameters
//   DepthWords  : memory size in 32-bit words (power of two, >= 2)
//   BaseWord    : first word address decoded by the agent
//   ReadLatency : cycles from read acceptance to readdatavalid (1..4)
//   MaxPending  : maximum accepted-but-unreturned reads (1..4)
//
// Ports
//   clk_i, rst_i        : clock, synchronous active-high reset
//   stall_i             : forces waitrequest high
//   avs_address         : word address
//   avs_byteenable      : write byte lanes
//   avs_read/avs_write  : request strobes (both high is treated as a write)
//   avs_writedata       : write data
//   avs_waitrequest     : combinational, request not accepted this cycle
//   avs_readdata        : read data, held between readdatavalid pulses
//   avs_readdatavalid   : one pulse per accepted read
//   avs_response        : 2'b00 OKAY, 2'b11 DECODEERROR
//
// Build option
//   AVS_DECODE_ERR_EN : out-of-range reads return DECODEERROR with zero data
//                       and out-of-range writes are dropped. When undefined
//                       the address aliases modulo DepthWords.
// ---------------------------------------------------------------------------
module avalon_sram_agent #(
    parameter int unsigned DepthWords  = 1024,
    parameter int unsigned BaseWord    = 0,
    parameter int unsigned ReadLatency = 2,
    parameter int unsigned MaxPending  = 2
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        stall_i,
    input  logic [31:0] avs_address,
    input  logic [3:0]  avs_byteenable,
    input  logic        avs_read,
    input  logic        avs_write,
    input  logic [31:0] avs_writedata,
    output logic        avs_waitrequest,
    output logic [31:0] avs_readdata,
    output logic        avs_readdatavalid,
    output logic [1:0]  avs_response
);

    localparam int unsigned AddrW = $clog2(DepthWords);
    localparam int unsigned PendW = $clog2(MaxPending + 1);
    localparam logic [1:0]  RespOkay = 2'b00;

    typedef struct packed {
        logic [1:0]  resp;
        logic [31:0] data;
    } beat_t;

    logic [31:0]            mem [DepthWords];
    logic [PendW-1:0]       pending;
    logic [ReadLatency-1:0] stage_valid;
    beat_t                  stage_beat [ReadLatency];

    logic             accept;
    logic             wr_accept;
    logic             rd_accept;
    logic             wr_enable;
    logic [AddrW-1:0] index;
    beat_t            rd_beat;

    // Back-pressure: reset, injected stall, or read limit reached.
    assign avs_waitrequest = rst_i | stall_i | (pending == PendW'(MaxPending));

    // A simultaneous read+write is a write; the read half is dropped.
    assign accept    = (avs_read | avs_write) & ~avs_waitrequest;
    assign wr_accept = accept & avs_write;
    assign rd_accept = accept & avs_read & ~avs_write;

`ifdef AVS_DECODE_ERR_EN
    localparam logic [1:0] RespDecErr = 2'b11;

    logic [31:0] offset;
    logic        in_range;

    assign offset   = avs_address - 32'(BaseWord);
    assign in_range = offset < 32'(DepthWords);
    assign index    = offset[AddrW-1:0];

    // Out-of-range reads answer with zero data and DECODEERROR.
    always_comb begin
        rd_beat   = '0;
        wr_enable = wr_accept & in_range;
        if (in_range) begin
            rd_beat.resp = RespOkay;
            rd_beat.data = mem[index];
        end else begin
            rd_beat.resp = RespDecErr;
            rd_beat.data = 32'h0;
        end
    end
`else
    // No range check: the offset wraps onto the memory.
    assign index = AddrW'(avs_address - 32'(BaseWord));

    always_comb begin
        rd_beat      = '0;
        wr_enable    = wr_accept;
        rd_beat.resp = RespOkay;
        rd_beat.data = mem[index];
    end
`endif

    // Byte-lane write port; contents survive reset.
    always_ff @(posedge clk_i) begin
        if (wr_enable) begin
            for (int i = 0; i < 4; i++) begin
                if (avs_byteenable[i]) begin
                    mem[index][8*i +: 8] <= avs_writedata[8*i +: 8];
                end
            end
        end
    end

    // Read return pipeline; data stages only load when a valid beat arrives,
    // so the last stage holds its value between readdatavalid pulses.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            stage_valid <= '0;
            for (int k = 0; k < int'(ReadLatency); k++) begin
                stage_beat[k] <= '0;
            end
        end else begin
            stage_valid[0] <= rd_accept;
            if (rd_accept) begin
                stage_beat[0] <= rd_beat;
            end
            for (int k = 1; k < int'(ReadLatency); k++) begin
                stage_valid[k] <= stage_valid[k-1];
                if (stage_valid[k-1]) begin
                    stage_beat[k] <= stage_beat[k-1];
                end
            end
        end
    end

    // Outstanding read count; accept and return together cancel out.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            pending <= '0;
        end else begin
            case ({rd_accept, avs_readdatavalid})
                2'b10:   pending <= pending + PendW'(1);
                2'b01:   pending <= pending - PendW'(1);
                default: pending <= pending;
            endcase
        end
    end

    assign avs_readdatavalid = stage_valid[ReadLatency-1];
    assign avs_readdata      = stage_beat[ReadLatency-1].data;
    assign avs_response      = stage_beat[ReadLatency-1].resp;

endmodule

// File: tb/tb_avalon_sram_agent.sv
// Bench for avalon_sram_agent: directed scenarios followed by random traffic.
// The driver keeps a word-array model of the memory and pushes expected read
// beats into a scoreboard; a separate monitor pops them on readdatavalid.
module tb_avalon_sram_agent;

    localparam int unsigned DEPTH = 1024;
    localparam int unsigned BASE  = 0;
    localparam int unsigned LAT   = 2;
    localparam int unsigned MAXP  = 2;

    logic        clk = 1'b0;
    logic        rst_i;
    logic        stall_i;
    logic [31:0] avs_address;
    logic [3:0]  avs_byteenable;
    logic        avs_read;
    logic        avs_write;
    logic [31:0] avs_writedata;
    logic        avs_waitrequest;
    logic [31:0] avs_readdata;
    logic        avs_readdatavalid;
    logic [1:0]  avs_response;

    always #5 clk = ~clk;

    avalon_sram_agent #(
        .DepthWords (DEPTH),
        .BaseWord   (BASE),
        .ReadLatency(LAT),
        .MaxPending (MAXP)
    ) dut (
        .clk_i            (clk),
        .rst_i            (rst_i),
        .stall_i          (stall_i),
        .avs_address      (avs_address),
        .avs_byteenable   (avs_byteenable),
        .avs_read         (avs_read),
        .avs_write        (avs_write),
        .avs_writedata    (avs_writedata),
        .avs_waitrequest  (avs_waitrequest),
        .avs_readdata     (avs_readdata),
        .avs_readdatavalid(avs_readdatavalid),
        .avs_response     (avs_response)
    );

    typedef struct {
        logic [31:0] data;
        logic [1:0]  resp;
        int          cyc;
    } exp_t;

    exp_t        sb[$];
    int          pend_q[$];
    logic [31:0] mdl [DEPTH];
    int          cyc = 0;
    int          n_checks = 0;
    int          n_pass = 0;
    bit          mon_en = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic void check(string name, logic [31:0] act, logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", name, act, exp, cyc);
    endfunction

    // Reference memory behaviour.
    function automatic void model_read(input logic [31:0] addr,
                                       output logic [31:0] d, output logic [1:0] r);
        logic [31:0] off;
        off = addr - BASE;
`ifdef AVS_DECODE_ERR_EN
        if (off >= DEPTH) begin
            d = 32'h0;
            r = 2'b11;
            return;
        end
`endif
        d = mdl[int'(off % DEPTH)];
        r = 2'b00;
    endfunction

    function automatic void model_write(input logic [31:0] addr, input logic [3:0] be,
                                        input logic [31:0] wd);
        logic [31:0] off;
        int          idx;
        off = addr - BASE;
`ifdef AVS_DECODE_ERR_EN
        if (off >= DEPTH) return;
`endif
        idx = int'(off % DEPTH);
        for (int i = 0; i < 4; i++)
            if (be[i]) mdl[idx][8*i +: 8] = wd[8*i +: 8];
    endfunction

    // Reads still outstanding in the current cycle.
    function automatic void prune_pending();
        while (pend_q.size() > 0 && pend_q[0] < cyc) void'(pend_q.pop_front());
    endfunction

    // One bus operation: present it, hold while waitrequest, log on acceptance.
    task automatic op(input bit rd, input bit wr, input logic [31:0] addr,
                      input logic [3:0] be, input logic [31:0] wd,
                      input int stall_cycles, output int waited);
        bit   done;
        exp_t e;
        waited = 0;
        done   = 1'b0;
        @(negedge clk);
        avs_read       = rd;
        avs_write      = wr;
        avs_address    = addr;
        avs_byteenable = be;
        avs_writedata  = wd;
        while (!done) begin
            stall_i = (waited < stall_cycles);
            #1;
            prune_pending();
            check("waitrequest", avs_waitrequest, stall_i || (pend_q.size() == MAXP));
            if (avs_waitrequest === 1'b0) begin
                if (wr) begin
                    model_write(addr, be, wd);
                end else if (rd) begin
                    model_read(addr, e.data, e.resp);
                    e.cyc = cyc + LAT;
                    sb.push_back(e);
                    pend_q.push_back(e.cyc);
                end
                done = 1'b1;
            end else if (waited >= 50) begin
                n_checks++;
                $display("FAIL accept_timeout: waited %0d cycles, required < 50", waited);
                done = 1'b1;
            end else begin
                waited++;
                @(negedge clk);
            end
        end
    endtask

    task automatic idle(input int n);
        int w;
        for (int i = 0; i < n; i++) op(1'b0, 1'b0, 32'h0, 4'h0, 32'h0, 0, w);
    endtask

    // Scoreboard monitor.
    always @(negedge clk) begin
        exp_t e;
        if (mon_en && avs_readdatavalid !== 1'b0) begin
            if (sb.size() == 0) begin
                check("unexpected_readdatavalid", 32'(avs_readdatavalid), 32'h0);
            end else begin
                e = sb.pop_front();
                check("readdata", avs_readdata, e.data);
                check("response", 32'(avs_response), 32'(e.resp));
                check("return_cycle", 32'(cyc), 32'(e.cyc));
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    int          w;
    int          bw [4];
    int          sel;
    int          guard;
    bit          rd_r;
    bit          wr_r;
    logic [31:0] a;

    initial begin
        rst_i = 1'b1;
        stall_i = 1'b0;
        avs_read = 1'b0;
        avs_write = 1'b0;
        avs_address = '0;
        avs_byteenable = '0;
        avs_writedata = '0;
        repeat (3) @(negedge clk);
        #1;
        check("reset_readdatavalid", 32'(avs_readdatavalid), 32'h0);
        check("reset_readdata", avs_readdata, 32'h0);
        check("reset_response", 32'(avs_response), 32'h0);
        check("reset_waitrequest", 32'(avs_waitrequest), 32'h1);
        @(negedge clk);
        rst_i  = 1'b0;
        mon_en = 1'b1;

        // Write then read back next cycle.
        op(1'b0, 1'b1, BASE + 5, 4'hF, 32'hDEADBEEF, 0, w);
        op(1'b1, 1'b0, BASE + 5, 4'h0, 32'h0, 0, w);
        // Byte-lane merge on one word.
        op(1'b0, 1'b1, BASE + 7, 4'hF, 32'h11223344, 0, w);
        op(1'b0, 1'b1, BASE + 7, 4'b1010, 32'hAA00BB00, 0, w);
        op(1'b1, 1'b0, BASE + 7, 4'h0, 32'h0, 0, w);
        idle(LAT + 2);

        // Fill the whole memory so any later address has a defined value.
        for (int i = 0; i < int'(DEPTH); i++)
            op(1'b0, 1'b1, BASE + i, 4'hF, $urandom, 0, w);
        idle(LAT + 2);

        // Four back-to-back reads: the third one waits one cycle on the limit.
        for (int i = 0; i < 4; i++) op(1'b1, 1'b0, BASE + i, 4'h0, 32'h0, 0, bw[i]);
        check("burst_wait0", 32'(bw[0]), 32'd0);
        check("burst_wait1", 32'(bw[1]), 32'd0);
        check("burst_wait2", 32'(bw[2]), 32'd1);
        check("burst_wait3", 32'(bw[3]), 32'd0);
        idle(LAT + 2);

        // Stall for three cycles: accepted in the first cycle after it falls.
        op(1'b1, 1'b0, BASE + 9, 4'h0, 32'h0, 3, w);
        check("stall_wait", 32'(w), 32'd3);
        idle(LAT + 2);

        // Just past the decoded window.
        op(1'b1, 1'b0, BASE + DEPTH, 4'h0, 32'h0, 0, w);
        idle(LAT + 2);

        // Reset with reads in flight.
        op(1'b1, 1'b0, BASE + 5, 4'h0, 32'h0, 0, w);
        op(1'b1, 1'b0, BASE + 7, 4'h0, 32'h0, 0, w);
        @(negedge clk);
        avs_read = 1'b0;
        avs_write = 1'b0;
        rst_i = 1'b1;
        #1;
        while (sb.size() > 0 && sb[$].cyc > cyc) void'(sb.pop_back());
        pend_q.delete();
        check("midreset_waitrequest", 32'(avs_waitrequest), 32'h1);
        @(negedge clk);
        rst_i = 1'b0;
        #1;
        check("postreset_readdatavalid", 32'(avs_readdatavalid), 32'h0);
        check("postreset_waitrequest", 32'(avs_waitrequest), 32'h0);
        idle(LAT + 3);
        op(1'b1, 1'b0, BASE + 5, 4'h0, 32'h0, 0, w);
        idle(LAT + 2);

        // Random traffic.
        for (int n = 0; n < 1500; n++) begin
            sel  = int'($urandom_range(0, 9));
            rd_r = (sel <= 3) || (sel == 7);
            wr_r = (sel >= 4) && (sel <= 7);
            if ($urandom_range(0, 9) == 0) a = $urandom;
            else a = BASE + $urandom_range(0, DEPTH - 1);
            op(rd_r, wr_r, a, 4'($urandom), $urandom,
               ($urandom_range(0, 4) == 0) ? int'($urandom_range(1, 3)) : 0, w);
        end

        idle(1);
        guard = 0;
        while (sb.size() > 0 && guard < 50) begin
            @(negedge clk);
            guard++;
        end
        #1;
        check("drain_empty", 32'(sb.size()), 32'h0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
